// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding, SPI mode constants and sizing limits for spi_master_param.
package spi_pkg;
   typedef enum logic [1:0] {IDLE, XFER, TRAIL} state_t;
   typedef enum int {CPOL_LOW = 0, CPOL_HIGH = 1} cpol_e;
   typedef enum int {CPHA_LEAD = 0, CPHA_TRAIL = 1} cpha_e;
   localparam int SPI_DW_MAX = 32;
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: CLK_DIV half-period divider, SCLK toggle register and toggle counter.
// The strobes are combinational and mark the clk edge on which SCLK toggles.
module spi_clkgen
   import spi_pkg::*;
#(
   parameter int DW = 12,
   parameter int CLK_DIV = 10,
   parameter int CPOL = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic xfer,
   input  logic trail,
   output logic sclk,
   output logic lead_stb,
   output logic trail_stb,
   output logic last,
   output logic tc
);
   localparam int CW = cnt_w(CLK_DIV);
   localparam int TW = $clog2(2 * DW + 1);
   localparam logic IDLE_LVL = (CPOL != CPOL_LOW);
   logic [CW-1:0] cnt;
   logic [TW-1:0] tcnt;
   logic tog;
   // the divider keeps running through TRAIL so it also times the cs hold
   assign tc = (xfer || trail) && (cnt == CW'(CLK_DIV - 1));
   assign tog = xfer && tc;
   assign lead_stb = tog && !tcnt[0];
   assign trail_stb = tog && tcnt[0];
   assign last = tog && (tcnt == TW'(2 * DW - 1));
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
         tcnt <= '0;
         sclk <= IDLE_LVL;
      end else if (start) begin
         cnt <= '0;
         tcnt <= '0;
         sclk <= IDLE_LVL;
      end else begin
         if (xfer || trail) cnt <= tc ? '0 : cnt + CW'(1);
         if (tog) begin
            sclk <= ~sclk;
            tcnt <= tcnt + TW'(1);
         end
      end
   end
endmodule

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master (DW, CLK_DIV, CPOL, CPHA), MSB first.
// Defining SPI_MASTER_LOOPBACK_EN adds input lpbk, which feeds the internal mosi into RX.
module spi_master_param
   import spi_pkg::*;
#(
   parameter int DW = 12,
   parameter int CLK_DIV = 10,
   parameter int CPOL = 0,
   parameter int CPHA = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          newd,
   input  logic [DW-1:0] din,
   input  logic          miso,
`ifdef SPI_MASTER_LOOPBACK_EN
   input  logic          lpbk,
`endif
   output logic          sclk,
   output logic          cs,
   output logic          mosi,
   output logic [DW-1:0] dout,
   output logic          busy,
   output logic          done
);
   localparam logic PHA = (CPHA == CPHA_TRAIL);
   state_t state, state_n;
   logic [DW-1:0] tx, tx_n, rx, rx_n, dout_n;
   logic cs_n, mosi_n, busy_n, done_n, start;
   logic lead_stb, trail_stb, last, tc, rx_bit, shift_stb, sample_stb;
`ifdef SPI_MASTER_LOOPBACK_EN
   assign rx_bit = lpbk ? mosi : miso;
`else
   assign rx_bit = miso;
`endif
   // mode 0/2 launches the first bit at acceptance, so the final trailing edge must not shift
   assign shift_stb = PHA ? lead_stb : (trail_stb && !last);
   assign sample_stb = PHA ? trail_stb : lead_stb;
   spi_clkgen #(
      .DW(DW),
      .CLK_DIV(CLK_DIV),
      .CPOL(CPOL)
   ) u_clkgen (
      .clk(clk),
      .rst(rst),
      .start(start),
      .xfer(state == XFER),
      .trail(state == TRAIL),
      .sclk(sclk),
      .lead_stb(lead_stb),
      .trail_stb(trail_stb),
      .last(last),
      .tc(tc)
   );
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cs <= 1'b1;
         mosi <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         dout <= '0;
         tx <= '0;
         rx <= '0;
      end else begin
         state <= state_n;
         cs <= cs_n;
         mosi <= mosi_n;
         busy <= busy_n;
         done <= done_n;
         dout <= dout_n;
         tx <= tx_n;
         rx <= rx_n;
      end
   end
   always_comb begin
      state_n = state;
      cs_n = cs;
      mosi_n = mosi;
      busy_n = busy;
      done_n = 1'b0;
      dout_n = dout;
      tx_n = tx;
      rx_n = rx;
      start = 1'b0;
      case (state)
         IDLE: if (newd) begin
            state_n = XFER;
            start = 1'b1;
            cs_n = 1'b0;
            busy_n = 1'b1;
            rx_n = '0;
            tx_n = PHA ? din : {din[DW-2:0], 1'b0};
            mosi_n = PHA ? 1'b0 : din[DW-1];
         end
         XFER: begin
            if (shift_stb) begin
               mosi_n = tx[DW-1];
               tx_n = {tx[DW-2:0], 1'b0};
            end
            if (sample_stb) rx_n = {rx[DW-2:0], rx_bit};
            if (last) state_n = TRAIL;
         end
         TRAIL: if (tc) begin
            state_n = IDLE;
            cs_n = 1'b1;
            mosi_n = 1'b0;
            busy_n = 1'b0;
            done_n = 1'b1;
            dout_n = rx;
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: directed checks of spi_master_param in all four modes, DW=8/CLK_DIV=1, reset abort
// and back-to-back transfers; the lpbk port is exercised when SPI_MASTER_LOOPBACK_EN is defined.
module tb_spi_master_param;
   import spi_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int base;
   logic newd0 = 1'b0;
   logic [11:0] din0 = '0;
   logic sclk0, cs0, mosi0, busy0, done0;
   logic [11:0] dout0;
   logic newdm = 1'b0;
   logic [11:0] dinm = 12'h3C5;
   logic newd4 = 1'b0;
   logic [7:0] din4 = 8'h3C;
   logic sclk4, cs4, mosi4, busy4, done4;
   logic [7:0] dout4;
`ifdef SPI_MASTER_LOOPBACK_EN
   logic newd5 = 1'b0;
   logic lpbk = 1'b0;
   logic [11:0] din5 = 12'h5A3;
   logic sclk5, cs5, mosi5, busy5, done5;
   logic [11:0] dout5;
`endif
   always #5 clk = ~clk;
   always @(posedge clk) if (done0) done_cnt <= done_cnt + 1;
   // mode 0, miso looped back externally
   spi_master_param #(.DW(12), .CLK_DIV(10), .CPOL(0), .CPHA(0)) u0 (
      .clk(clk), .rst(rst), .newd(newd0), .din(din0), .miso(mosi0),
`ifdef SPI_MASTER_LOOPBACK_EN
      .lpbk(1'b0),
`endif
      .sclk(sclk0), .cs(cs0), .mosi(mosi0), .dout(dout0), .busy(busy0), .done(done0)
   );
   // modes 1..3 against a slave that returns 12'hA5A and captures mosi on its sampling edge
   for (genvar m = 1; m <= 3; m++) begin : g
      localparam logic POL = (m >= 2);
      localparam logic PHA = (m % 2 == 1);
      logic sclk, cs, mosi, miso, busy, done, sprev;
      logic [11:0] dout, sreg, cap;
      spi_master_param #(.DW(12), .CLK_DIV(10), .CPOL(m / 2), .CPHA(m % 2)) u (
         .clk(clk), .rst(rst), .newd(newdm), .din(dinm), .miso(miso),
`ifdef SPI_MASTER_LOOPBACK_EN
         .lpbk(1'b0),
`endif
         .sclk(sclk), .cs(cs), .mosi(mosi), .dout(dout), .busy(busy), .done(done)
      );
      always @(negedge clk) begin
         sprev <= sclk;
         if (rst || cs) begin
            sreg <= PHA ? 12'hA5A : 12'h4B4;
            miso <= !PHA;
         end else if (sclk != sprev) begin
            if ((sclk != POL) != PHA) cap <= {cap[10:0], mosi};
            else begin
               miso <= sreg[11];
               sreg <= {sreg[10:0], 1'b0};
            end
         end
      end
   end
   spi_master_param #(.DW(8), .CLK_DIV(1), .CPOL(0), .CPHA(0)) u4 (
      .clk(clk), .rst(rst), .newd(newd4), .din(din4), .miso(mosi4),
`ifdef SPI_MASTER_LOOPBACK_EN
      .lpbk(1'b0),
`endif
      .sclk(sclk4), .cs(cs4), .mosi(mosi4), .dout(dout4), .busy(busy4), .done(done4)
   );
`ifdef SPI_MASTER_LOOPBACK_EN
   spi_master_param #(.DW(12), .CLK_DIV(10), .CPOL(0), .CPHA(0)) u5 (
      .clk(clk), .rst(rst), .newd(newd5), .din(din5), .miso(1'b0), .lpbk(lpbk),
      .sclk(sclk5), .cs(cs5), .mosi(mosi5), .dout(dout5), .busy(busy5), .done(done5)
   );
`endif
   task automatic chk(input string tag, input logic [SPI_DW_MAX-1:0] got, input logic [SPI_DW_MAX-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      tick(3);
      @(negedge clk) rst = 1'b0;
      tick(2);
      chk("rst_cs", 32'(cs0), 32'd1);
      chk("rst_sclk", 32'(sclk0), 32'd0);
      chk("rst_mosi", 32'(mosi0), 32'd0);
      chk("rst_dout", 32'(dout0), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("idle_sclk_m1", 32'(g[1].sclk), 32'd0);
      chk("idle_sclk_m2", 32'(g[2].sclk), 32'd1);
      chk("idle_sclk_m3", 32'(g[3].sclk), 32'd1);
      chk("rst_cs4", 32'(cs4), 32'd1);
      // mode 0 loopback plus modes 1..3, launched together
      @(negedge clk);
      din0 = 12'h95C;
      newd0 = 1'b1;
      newdm = 1'b1;
      @(posedge clk);
      #1;
      newd0 = 1'b0;
      newdm = 1'b0;
      chk("acc_busy", 32'(busy0), 32'd1);
      chk("acc_cs", 32'(cs0), 32'd0);
      chk("acc_mosi", 32'(mosi0), 32'd1);
      chk("acc_sclk_m2", 32'(g[2].sclk), 32'd1);
      for (int i = 0; i < 12; i++) begin
         tick(i == 0 ? 10 : 20);
         chk("mosi_bit", 32'(mosi0), 32'(din0[11-i]));
         chk("lead_sclk", 32'(sclk0), 32'd1);
      end
      tick(19);
      chk("c249_cs", 32'(cs0), 32'd0);
      chk("c249_done", 32'(done0), 32'd0);
      chk("c249_busy", 32'(busy0), 32'd1);
      tick(1);
      chk("c250_cs", 32'(cs0), 32'd1);
      chk("c250_done", 32'(done0), 32'd1);
      chk("c250_busy", 32'(busy0), 32'd0);
      chk("c250_dout", 32'(dout0), 32'h95C);
      chk("m1_done", 32'(g[1].done), 32'd1);
      chk("m2_done", 32'(g[2].done), 32'd1);
      chk("m3_done", 32'(g[3].done), 32'd1);
      chk("m1_busy", 32'(g[1].busy), 32'd0);
      chk("m2_busy", 32'(g[2].busy), 32'd0);
      chk("m3_busy", 32'(g[3].busy), 32'd0);
      chk("m1_dout", 32'(g[1].dout), 32'hA5A);
      chk("m2_dout", 32'(g[2].dout), 32'hA5A);
      chk("m3_dout", 32'(g[3].dout), 32'hA5A);
      chk("m1_cap", 32'(g[1].cap), 32'h3C5);
      chk("m2_cap", 32'(g[2].cap), 32'h3C5);
      chk("m3_cap", 32'(g[3].cap), 32'h3C5);
      chk("m1_sclk_end", 32'(g[1].sclk), 32'd0);
      chk("m2_sclk_end", 32'(g[2].sclk), 32'd1);
      chk("m3_sclk_end", 32'(g[3].sclk), 32'd1);
      tick(1);
      chk("c251_done", 32'(done0), 32'd0);
      // newd held high: three back-to-back transfers, din changes while busy
      tick(5);
      base = done_cnt;
      @(negedge clk);
      din0 = 12'h123;
      newd0 = 1'b1;
      @(posedge clk);
      #1;
      tick(5);
      din0 = 12'hFFF;
      tick(245);
      chk("b2b1_done", 32'(done0), 32'd1);
      chk("b2b1_dout", 32'(dout0), 32'h123);
      chk("b2b1_gap_cs", 32'(cs0), 32'd1);
      tick(1);
      chk("b2b2_acc_cs", 32'(cs0), 32'd0);
      chk("b2b2_acc_busy", 32'(busy0), 32'd1);
      tick(10);
      din0 = 12'h0F0;
      tick(240);
      chk("b2b2_done", 32'(done0), 32'd1);
      chk("b2b2_dout", 32'(dout0), 32'hFFF);
      chk("b2b2_gap_cs", 32'(cs0), 32'd1);
      tick(1);
      chk("b2b3_acc_cs", 32'(cs0), 32'd0);
      tick(100);
      newd0 = 1'b0;
      tick(150);
      chk("b2b3_done", 32'(done0), 32'd1);
      chk("b2b3_dout", 32'(dout0), 32'h0F0);
      tick(10);
      chk("b2b_done_count", 32'(done_cnt - base), 32'd3);
      chk("b2b_end_busy", 32'(busy0), 32'd0);
      chk("b2b_end_cs", 32'(cs0), 32'd1);
      // reset at cycle 100 of a transfer
      @(negedge clk);
      din0 = 12'h6B1;
      newd0 = 1'b1;
      @(posedge clk);
      #1;
      newd0 = 1'b0;
      tick(100);
      rst = 1'b1;
      #1;
      chk("arst_cs", 32'(cs0), 32'd1);
      chk("arst_busy", 32'(busy0), 32'd0);
      chk("arst_dout", 32'(dout0), 32'd0);
      chk("arst_sclk", 32'(sclk0), 32'd0);
      chk("arst_mosi", 32'(mosi0), 32'd0);
      base = done_cnt;
      tick(2);
      @(negedge clk) rst = 1'b0;
      tick(300);
      chk("arst_no_done", 32'(done_cnt - base), 32'd0);
      @(negedge clk);
      din0 = 12'h2D4;
      newd0 = 1'b1;
      @(posedge clk);
      #1;
      newd0 = 1'b0;
      tick(250);
      chk("post_rst_done", 32'(done0), 32'd1);
      chk("post_rst_dout", 32'(dout0), 32'h2D4);
      // DW=8, CLK_DIV=1
      tick(3);
      @(negedge clk) newd4 = 1'b1;
      @(posedge clk);
      #1;
      newd4 = 1'b0;
      chk("d8_mosi0", 32'(mosi4), 32'd0);
      chk("d8_cs", 32'(cs4), 32'd0);
      tick(1);
      chk("d8_sclk_c1", 32'(sclk4), 32'd1);
      tick(1);
      chk("d8_sclk_c2", 32'(sclk4), 32'd0);
      tick(1);
      chk("d8_sclk_c3", 32'(sclk4), 32'd1);
      tick(13);
      chk("d8_c16_done", 32'(done4), 32'd0);
      chk("d8_c16_busy", 32'(busy4), 32'd1);
      tick(1);
      chk("d8_c17_done", 32'(done4), 32'd1);
      chk("d8_c17_dout", 32'(dout4), 32'h3C);
      chk("d8_c17_cs", 32'(cs4), 32'd1);
      chk("d8_c17_busy", 32'(busy4), 32'd0);
`ifdef SPI_MASTER_LOOPBACK_EN
      tick(3);
      chk("lb_idle_sclk", 32'(sclk5), 32'd0);
      @(negedge clk);
      lpbk = 1'b1;
      newd5 = 1'b1;
      @(posedge clk);
      #1;
      newd5 = 1'b0;
      tick(250);
      chk("lb1_done", 32'(done5), 32'd1);
      chk("lb1_dout", 32'(dout5), 32'h5A3);
      chk("lb1_mosi", 32'(mosi5), 32'd0);
      tick(3);
      @(negedge clk);
      lpbk = 1'b0;
      newd5 = 1'b1;
      @(posedge clk);
      #1;
      newd5 = 1'b0;
      tick(250);
      chk("lb0_done", 32'(done5), 32'd1);
      chk("lb0_dout", 32'(dout5), 32'd0);
      chk("lb0_cs", 32'(cs5), 32'd1);
      chk("lb0_busy", 32'(busy5), 32'd0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master, successor to the fixed 12-bit transmit-only SPI block. It adds configurable word width, SCLK divider and SPI mode (CPOL/CPHA), plus full-duplex receive on `miso` with a `busy`/`done` handshake. It sits between on-chip control logic and one external SPI slave, with one transfer per `newd` request.

## Interface
- `DW`, 12: word width in bits, ≥2.
- `CLK_DIV`, 10: SCLK half-period in `clk` cycles, ≥1.
- `CPOL`, 0: SCLK idle level.
- `CPHA`, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `newd`  in  1  transfer request; level-sampled in IDLE only.
- `din`  in  DW  transmit word; captured when the request is accepted.
- `miso`  in  1  serial data from the slave.
- `sclk`  out  1  SPI clock.
- `cs`  out  1  chip select, active-low.
- `mosi`  out  1  serial data to the slave, MSB first.
- `dout`  out  DW  last received word; held until the next `done`.
- `busy`  out  1  high from acceptance until `done`.
- `done`  out  1  one-cycle pulse at end of transfer.

## Operation
- States: IDLE, XFER, TRAIL.
- IDLE
  - Outputs: `cs`=1, `sclk`=CPOL, `mosi`=0, `busy`=0.
  - `newd`=1 at an edge: latch `din` into the TX shift register, `cs`←0, `busy`←1, clear the divider and edge counters, go to XFER.
  - CPHA=0: `mosi`←`din[DW-1]` on that same edge.
- XFER
  - The divider counts 0..CLK_DIV-1. At terminal count `sclk` toggles and the counter wraps. Exactly 2·DW toggles occur.
  - Odd toggles are leading edges; even toggles are trailing edges.
  - CPHA=0: sample `miso` into RX on leading edges. Shift the next TX bit onto `mosi` on trailing edges, except the final one.
  - CPHA=1: shift the TX bit onto `mosi` on leading edges. Sample on trailing edges.
  - After toggle 2·DW, `sclk` is back at CPOL. Go to TRAIL.
- TRAIL
  - Hold `cs`=0 for CLK_DIV cycles.
  - Then, on one edge: `cs`←1, `mosi`←0, `dout`←RX, `done`←1, `busy`←0. Go to IDLE.
- `newd` and `din` are ignored while `busy`=1. No queueing.
- `newd` held high gives back-to-back transfers with exactly one IDLE cycle (`cs` high) between them.
- `miso` is sampled directly; the slave must meet setup to the sampling `clk` edge.

## Timing
- Reset values: `cs`=1, `sclk`=CPOL, `mosi`=0, `dout`=0, `busy`=0, `done`=0; state IDLE.
- Reset asserted mid-transfer aborts immediately and asynchronously to the values above. No `done` pulse. Partial RX is discarded.
- Take cycle 0 as the acceptance edge.
  - SCLK toggles occur at cycles k·CLK_DIV for k=1..2·DW.
  - `cs` rises, and `done` and `dout` update, at cycle (2·DW+1)·CLK_DIV.
  - Earliest next acceptance is at cycle (2·DW+1)·CLK_DIV+1.
- CPHA=0: the first `mosi` bit is valid CLK_DIV cycles before the first SCLK edge.
- CPHA=1: `mosi` changes on the leading SCLK edge itself. This is launched from registers, so it is valid for the whole following half-period.
- `done` is high for exactly one cycle. `busy` and `done` are never high together.
- CLK_DIV=1 is legal: SCLK = `clk`/2.

## Configuration
- `SPI_MASTER_LOOPBACK_EN`
  - Defined: adds input `lpbk` (1 bit). When `lpbk`=1, RX samples the internal `mosi` instead of `miso`, and external pins behave unchanged. `lpbk` is sampled per bit.
  - Undefined: the port is absent and RX always samples `miso`.

## Structure
- Package `spi_pkg` holds:
  - state enum (IDLE/XFER/TRAIL);
  - CPOL/CPHA mode constants;
  - a `SPI_DW_MAX` localparam for bench sizing.
- Sub-module `spi_clkgen` contains:
  - the CLK_DIV divider;
  - the SCLK toggle register and toggle counter.
  - It outputs a one-cycle `lead_stb`/`trail_stb` and `last` to the FSM.
- The top level holds the FSM and the TX/RX shift registers.

## Test plan
- DW=12, CLK_DIV=10, mode 0, `din`=12'h95C, `miso` tied to `mosi` externally.
  - `mosi` shows 1,0,0,1,0,1,0,1,1,1,0,0.
  - `cs` is low for 250 cycles.
  - `dout`=12'h95C with `done` at cycle 250.
- Modes 1, 2 and 3 with a slave model returning 12'hA5A.
  - Idle `sclk` level matches CPOL.
  - `dout`=12'hA5A in every mode.
  - Bench-side sampling edge matches CPHA.
- `newd` held high for three transfers.
  - Exactly one IDLE cycle with `cs`=1 between transfers.
  - Exactly three `done` pulses.
  - `din` change during `busy` is ignored.
- `rst` asserted at cycle 100 of a transfer.
  - `cs`=1, `busy`=0 and `dout`=0 asynchronously.
  - No `done` pulse.
  - The next transfer completes correctly.
- DW=8, CLK_DIV=1.
  - SCLK period is 2 cycles.
  - `done` at cycle 17.
  - `dout` correct for 8'h3C.
- `SPI_MASTER_LOOPBACK_EN` defined, `lpbk`=1, `miso` tied to 0.
  - `dout`=`din`=12'h5A3.
  - With `lpbk`=0, `dout`=0.
